// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one block-serial multiplier between clients A and B.
// Operand and result paths each add 1 cycle; the grant is held from LOAD until the forwarded final.
module multiplier_arbiter #(
    parameter int REGISTER_SIZE = 32,
    parameter int BITS_IN_NUM   = 4096
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     a_req_in,
    input  logic                     b_req_in,
    input  logic [REGISTER_SIZE-1:0] a_n_in,
    input  logic [REGISTER_SIZE-1:0] a_m_in,
    input  logic [REGISTER_SIZE-1:0] b_n_in,
    input  logic [REGISTER_SIZE-1:0] b_m_in,
    input  logic                     a_valid_in,
    input  logic                     b_valid_in,
    output logic                     a_grant_out,
    output logic                     b_grant_out,
    output logic [REGISTER_SIZE-1:0] a_data_out,
    output logic [REGISTER_SIZE-1:0] b_data_out,
    output logic                     a_valid_out,
    output logic                     b_valid_out,
    output logic                     a_final_out,
    output logic                     b_final_out,
    output logic [REGISTER_SIZE-1:0] mult_n_out,
    output logic [REGISTER_SIZE-1:0] mult_m_out,
    output logic                     mult_valid_out,
    input  logic                     mult_ready_in,
    input  logic [REGISTER_SIZE-1:0] mult_data_in,
    input  logic                     mult_valid_in,
    input  logic                     mult_final_in,
    output logic                     busy_out
);

    localparam int BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
    localparam int CNT_W  = $clog2(BLOCKS + 1);
    localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(BLOCKS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;
    typedef enum logic {CLI_A, CLI_B} client_t;

    state_t                  state, state_nx;
    client_t                 owner, owner_nx;
    client_t                 last_served, last_served_nx;
    logic [CNT_W-1:0]        blk_cnt, blk_cnt_nx;

    logic [REGISTER_SIZE-1:0] mult_n_nx, mult_m_nx;
    logic                     mult_valid_nx;
    logic [REGISTER_SIZE-1:0] a_data_nx, b_data_nx;
    logic                     a_valid_nx, b_valid_nx;
    logic                     a_final_nx, b_final_nx;

    logic                     own_valid;
    logic [REGISTER_SIZE-1:0] own_n, own_m;

    // Operand mux: the non-owner's inputs never reach the multiplier.
    assign own_valid = (owner == CLI_A) ? a_valid_in : b_valid_in;
    assign own_n     = (owner == CLI_A) ? a_n_in     : b_n_in;
    assign own_m     = (owner == CLI_A) ? a_m_in     : b_m_in;

    assign busy_out    = (state != IDLE);
    assign a_grant_out = (state != IDLE) && (owner == CLI_A);
    assign b_grant_out = (state != IDLE) && (owner == CLI_B);

    always_comb begin
        state_nx       = state;
        owner_nx       = owner;
        last_served_nx = last_served;
        blk_cnt_nx     = blk_cnt;
        mult_n_nx      = mult_n_out;
        mult_m_nx      = mult_m_out;
        mult_valid_nx  = 1'b0;
        a_data_nx      = '0;
        b_data_nx      = '0;
        a_valid_nx     = 1'b0;
        b_valid_nx     = 1'b0;
        a_final_nx     = 1'b0;
        b_final_nx     = 1'b0;

        case (state)
            IDLE: begin
                if (mult_ready_in && (a_req_in || b_req_in)) begin
                    if (a_req_in && b_req_in) begin
                        owner_nx = (last_served == CLI_B) ? CLI_A : CLI_B;
                    end else begin
                        owner_nx = a_req_in ? CLI_A : CLI_B;
                    end
                    blk_cnt_nx = '0;
                    state_nx   = LOAD;
                end
            end
            LOAD: begin
                if (own_valid) begin
                    mult_n_nx     = own_n;
                    mult_m_nx     = own_m;
                    mult_valid_nx = 1'b1;
                    if (blk_cnt == LAST_BLK) begin
                        blk_cnt_nx = '0;
                        state_nx   = WAIT;
                    end else begin
                        blk_cnt_nx = blk_cnt + CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (owner == CLI_A) begin
                    a_data_nx  = mult_data_in;
                    a_valid_nx = mult_valid_in;
                    a_final_nx = mult_final_in;
                end else begin
                    b_data_nx  = mult_data_in;
                    b_valid_nx = mult_valid_in;
                    b_final_nx = mult_final_in;
                end
                // Grant release coincides with the forwarded final pulse.
                if (mult_final_in) begin
                    last_served_nx = owner;
                    state_nx       = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            owner          <= CLI_A;
            last_served    <= CLI_B;
            blk_cnt        <= '0;
            mult_n_out     <= '0;
            mult_m_out     <= '0;
            mult_valid_out <= 1'b0;
            a_data_out     <= '0;
            b_data_out     <= '0;
            a_valid_out    <= 1'b0;
            b_valid_out    <= 1'b0;
            a_final_out    <= 1'b0;
            b_final_out    <= 1'b0;
        end else begin
            state          <= state_nx;
            owner          <= owner_nx;
            last_served    <= last_served_nx;
            blk_cnt        <= blk_cnt_nx;
            mult_n_out     <= mult_n_nx;
            mult_m_out     <= mult_m_nx;
            mult_valid_out <= mult_valid_nx;
            a_data_out     <= a_data_nx;
            b_data_out     <= b_data_nx;
            a_valid_out    <= a_valid_nx;
            b_valid_out    <= b_valid_nx;
            a_final_out    <= a_final_nx;
            b_final_out    <= b_final_nx;
        end
    end

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Bench for multiplier_arbiter with a behavioural block-serial multiplier and two client drivers.
module tb_multiplier_arbiter;
    localparam int RS  = 32;
    localparam int BN  = 128;
    localparam int NBLK = BN / RS;

    typedef struct {int cyc; logic [RS-1:0] n; logic [RS-1:0] m;} blk_t;
    typedef struct {int cyc; int who;} ev_t;

    logic clk = 1'b0;
    logic rst;
    logic a_req, b_req, a_vld, b_vld;
    logic [RS-1:0] a_n, a_m, b_n, b_m;
    logic a_grant_out, b_grant_out, a_valid_out, b_valid_out, a_final_out, b_final_out;
    logic [RS-1:0] a_data_out, b_data_out, mult_n_out, mult_m_out, m_data;
    logic mult_valid_out, mult_ready_in, m_ready, ready_en, m_valid, m_final, busy_out;
    bit stray;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int leak = 0;

    blk_t fwd_q[$], sent_q[$];
    ev_t grant_q[$], final_q[$], drop_q[$];
    logic [2*BN-1:0] got_a[$], got_b[$], exp_a[$], exp_b[$];

    always #5 clk = ~clk;
    assign mult_ready_in = m_ready & ready_en;

    multiplier_arbiter #(.REGISTER_SIZE(RS), .BITS_IN_NUM(BN)) dut (
        .clk_in(clk), .rst_in(rst),
        .a_req_in(a_req), .b_req_in(b_req),
        .a_n_in(a_n), .a_m_in(a_m), .b_n_in(b_n), .b_m_in(b_m),
        .a_valid_in(a_vld), .b_valid_in(b_vld),
        .a_grant_out(a_grant_out), .b_grant_out(b_grant_out),
        .a_data_out(a_data_out), .b_data_out(b_data_out),
        .a_valid_out(a_valid_out), .b_valid_out(b_valid_out),
        .a_final_out(a_final_out), .b_final_out(b_final_out),
        .mult_n_out(mult_n_out), .mult_m_out(mult_m_out), .mult_valid_out(mult_valid_out),
        .mult_ready_in(mult_ready_in), .mult_data_in(m_data),
        .mult_valid_in(m_valid), .mult_final_in(m_final),
        .busy_out(busy_out)
    );

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Behavioural multiplier: gathers NBLK operand blocks, waits, streams 2*NBLK product blocks.
    initial begin
        int mst, mcnt, mdly;
        logic [BN-1:0] opn, opm;
        logic [2*BN-1:0] prod;
        mst = 0; mcnt = 0; mdly = 0; opn = '0; opm = '0; prod = '0;
        m_ready = 1'b1; m_valid = 1'b0; m_final = 1'b0; m_data = '0;
        forever begin
            @(posedge clk);
            #1;
            m_valid = 1'b0; m_final = 1'b0; m_data = '0;
            if (rst) begin
                mst = 0; mcnt = 0; m_ready = 1'b1;
            end else begin
                case (mst)
                    0: begin
                        if (mult_valid_out) begin
                            opn[mcnt*RS +: RS] = mult_n_out;
                            opm[mcnt*RS +: RS] = mult_m_out;
                            mcnt++;
                            m_ready = 1'b0;
                            if (mcnt == NBLK) begin
                                prod = {{BN{1'b0}}, opn} * {{BN{1'b0}}, opm};
                                mdly = $urandom_range(2, 4);
                                mcnt = 0;
                                mst = 1;
                            end
                        end
                        if (stray) begin
                            m_valid = 1'b1;
                            m_data = $urandom;
                        end
                    end
                    1: begin
                        if (mdly == 0) mst = 2;
                        else mdly--;
                    end
                    2: begin
                        m_valid = 1'b1;
                        m_data = prod[mcnt*RS +: RS];
                        if (mcnt == 2*NBLK-1) begin
                            m_final = 1'b1;
                            mcnt = 0;
                            mst = 3;
                        end else begin
                            mcnt++;
                        end
                    end
                    default: begin
                        m_ready = 1'b1;
                        mst = 0;
                    end
                endcase
            end
        end
    end

    // Passive recorder of forwarded operands, grants, finals and result streams.
    initial begin
        logic pa_g, pb_g;
        logic [2*BN-1:0] acc_a, acc_b;
        int ia, ib;
        pa_g = 1'b0; pb_g = 1'b0; acc_a = '0; acc_b = '0; ia = 0; ib = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_a = '0; acc_b = '0; ia = 0; ib = 0;
            end
            if (mult_valid_out) fwd_q.push_back('{cyc, mult_n_out, mult_m_out});
            if (a_grant_out && !pa_g) grant_q.push_back('{cyc, 0});
            if (b_grant_out && !pb_g) grant_q.push_back('{cyc, 1});
            if (!a_grant_out && pa_g) drop_q.push_back('{cyc, 0});
            if (!b_grant_out && pb_g) drop_q.push_back('{cyc, 1});
            if ((a_valid_out || a_final_out || a_data_out != '0) && !pa_g) leak++;
            if ((b_valid_out || b_final_out || b_data_out != '0) && !pb_g) leak++;
            if (a_valid_out) begin
                if (ia < 2*NBLK) acc_a[ia*RS +: RS] = a_data_out;
                ia++;
            end
            if (b_valid_out) begin
                if (ib < 2*NBLK) acc_b[ib*RS +: RS] = b_data_out;
                ib++;
            end
            if (a_final_out) begin
                got_a.push_back((ia == 2*NBLK) ? acc_a : '1);
                final_q.push_back('{cyc, 0});
                acc_a = '0; ia = 0;
            end
            if (b_final_out) begin
                got_b.push_back((ib == 2*NBLK) ? acc_b : '1);
                final_q.push_back('{cyc, 1});
                acc_b = '0; ib = 0;
            end
            pa_g = a_grant_out;
            pb_g = b_grant_out;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion by 1ms, want summary");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_logs();
        fwd_q.delete(); sent_q.delete(); grant_q.delete(); final_q.delete(); drop_q.delete();
        got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
        leak = 0;
    endtask

    task automatic set_req(input int who, input logic v);
        if (who == 0) a_req = v; else b_req = v;
    endtask

    task automatic set_vld(input int who, input logic v, input logic [RS-1:0] n, input logic [RS-1:0] m);
        if (who == 0) begin a_vld = v; a_n = n; a_m = m; end
        else begin b_vld = v; b_n = n; b_m = m; end
    endtask

    function automatic logic grant_of(input int who);
        return (who == 0) ? a_grant_out : b_grant_out;
    endfunction

    function automatic logic final_of(input int who);
        return (who == 0) ? a_final_out : b_final_out;
    endfunction

    // Client driver: requests, sends NBLK operand blocks with gaps, waits for its final.
    task automatic client(input int who, input int njobs, input bit fixed,
                          input logic [BN-1:0] fn, input logic [BN-1:0] fm,
                          input int g0, input int g1, input int g2, input int g3,
                          input bit extra, input bit drop_in_wait,
                          output int wait_cyc, output int tmo);
        int gaps[4];
        int w;
        logic [BN-1:0] n, m;
        gaps[0] = g0; gaps[1] = g1; gaps[2] = g2; gaps[3] = g3;
        tmo = 0; wait_cyc = 0;
        @(negedge clk);
        set_req(who, 1'b1);
        for (int j = 0; j < njobs; j++) begin
            w = 0;
            do begin
                set_vld(who, 1'($urandom_range(0, 1)), $urandom, $urandom);
                @(negedge clk);
                w++;
            end while (!grant_of(who) && w < 400);
            if (j == 0) wait_cyc = w;
            if (!grant_of(who)) begin
                tmo++;
                set_vld(who, 1'b0, '0, '0);
                set_req(who, 1'b0);
                return;
            end
            if (fixed) begin n = fn; m = fm; end
            else begin
                n = {$urandom, $urandom, $urandom, $urandom};
                m = {$urandom, $urandom, $urandom, $urandom};
            end
            if (who == 0) exp_a.push_back({{BN{1'b0}}, n} * {{BN{1'b0}}, m});
            else exp_b.push_back({{BN{1'b0}}, n} * {{BN{1'b0}}, m});
            for (int i = 0; i < NBLK; i++) begin
                repeat (gaps[i]) begin
                    set_vld(who, 1'b0, $urandom, $urandom);
                    @(negedge clk);
                end
                set_vld(who, 1'b1, n[i*RS +: RS], m[i*RS +: RS]);
                sent_q.push_back('{cyc + 1, n[i*RS +: RS], m[i*RS +: RS]});
                @(negedge clk);
            end
            if (extra) begin
                set_vld(who, 1'b1, $urandom, $urandom);
                @(negedge clk);
            end
            set_vld(who, 1'b0, '0, '0);
            if (j == njobs - 1 && drop_in_wait) set_req(who, 1'b0);
            w = 0;
            while (!final_of(who) && w < 400) begin
                @(negedge clk);
                w++;
            end
            if (!final_of(who)) tmo++;
        end
        set_req(who, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a_grant_out, b_grant_out, busy_out, mult_valid_out} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 0000", {a_grant_out, b_grant_out, busy_out, mult_valid_out});
        end
        n_cmp++;
        if ({a_valid_out, b_valid_out, a_final_out, b_final_out, a_data_out, b_data_out, mult_n_out, mult_m_out} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got nonzero result/operand outputs want all 0");
        end
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_single_a();
        int w, t;
        clear_logs();
        client(0, 1, 1'b1, 128'd3, 128'd5, 0, 0, 0, 0, 1'b0, 1'b0, w, t);
        n_cmp++;
        if ({busy_out, a_grant_out, a_final_out} !== 3'b001) begin
            n_err++;
            $display("FAIL single_release: got busy/grant/final %b want 001", {busy_out, a_grant_out, a_final_out});
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (t !== 0 || w !== 1) begin
            n_err++;
            $display("FAIL single_grant_lat: got wait %0d tmo %0d want 1 / 0", w, t);
        end
        n_cmp++;
        if (fwd_q.size() !== NBLK) begin
            n_err++;
            $display("FAIL single_fwd_count: got %0d want %0d", fwd_q.size(), NBLK);
        end
        for (int i = 0; i < fwd_q.size() && i < sent_q.size(); i++) begin
            n_cmp++;
            if (fwd_q[i].cyc !== sent_q[i].cyc || fwd_q[i].n !== sent_q[i].n || fwd_q[i].m !== sent_q[i].m) begin
                n_err++;
                $display("FAIL single_fwd[%0d]: got cyc %0d n %h m %h want cyc %0d n %h m %h", i,
                         fwd_q[i].cyc, fwd_q[i].n, fwd_q[i].m, sent_q[i].cyc, sent_q[i].n, sent_q[i].m);
            end
        end
        n_cmp++;
        if (got_a.size() !== 1 || got_b.size() !== 0) begin
            n_err++;
            $display("FAIL single_final_count: got a %0d b %0d want 1 0", got_a.size(), got_b.size());
        end else begin
            n_cmp++;
            if (got_a[0] !== 256'd15) begin
                n_err++;
                $display("FAIL single_product: got %h want 15", got_a[0]);
            end
        end
        n_cmp++;
        if (drop_q.size() !== 1 || final_q.size() !== 1 || drop_q[0].cyc !== final_q[0].cyc) begin
            n_err++;
            $display("FAIL single_drop_vs_final: got drops %0d finals %0d want equal cycles", drop_q.size(), final_q.size());
        end
        n_cmp++;
        if (leak !== 0) begin
            n_err++;
            $display("FAIL single_leak: got %0d want 0", leak);
        end
    endtask

    task automatic test_simultaneous();
        int wa, ta, wb, tb;
        do_reset();
        fork
            client(0, 2, 1'b0, '0, '0, 0, 0, 0, 0, 1'b0, 1'b0, wa, ta);
            client(1, 2, 1'b0, '0, '0, 0, 0, 0, 0, 1'b0, 1'b0, wb, tb);
        join
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ta !== 0 || tb !== 0 || grant_q.size() !== 4 || final_q.size() !== 4) begin
            n_err++;
            $display("FAIL simul_counts: got tmo %0d/%0d grants %0d finals %0d want 0/0 4 4", ta, tb, grant_q.size(), final_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (grant_q[k].who !== (k % 2)) begin
                    n_err++;
                    $display("FAIL simul_order[%0d]: got client %0d want %0d", k, grant_q[k].who, k % 2);
                end
                if (k > 0) begin
                    n_cmp++;
                    if (grant_q[k].cyc !== final_q[k-1].cyc + 1) begin
                        n_err++;
                        $display("FAIL simul_gap[%0d]: got grant cyc %0d want %0d", k, grant_q[k].cyc, final_q[k-1].cyc + 1);
                    end
                end
            end
        end
        n_cmp++;
        if (got_a != exp_a || got_b != exp_b) begin
            n_err++;
            $display("FAIL simul_products: got %0d/%0d results, contents differ from expected %0d/%0d", got_a.size(), got_b.size(), exp_a.size(), exp_b.size());
        end
    endtask

    task automatic test_valid_gaps();
        int w, t;
        clear_logs();
        client(0, 1, 1'b0, '0, '0, 0, 1, 2, 0, 1'b1, 1'b0, w, t);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (t !== 0 || fwd_q.size() !== NBLK) begin
            n_err++;
            $display("FAIL gaps_fwd_count: got %0d (tmo %0d) want %0d", fwd_q.size(), t, NBLK);
        end
        for (int i = 0; i < fwd_q.size() && i < sent_q.size(); i++) begin
            n_cmp++;
            if (fwd_q[i].cyc !== sent_q[i].cyc || fwd_q[i].n !== sent_q[i].n || fwd_q[i].m !== sent_q[i].m) begin
                n_err++;
                $display("FAIL gaps_fwd[%0d]: got cyc %0d want cyc %0d", i, fwd_q[i].cyc, sent_q[i].cyc);
            end
        end
        n_cmp++;
        if (got_a.size() !== 1 || exp_a.size() !== 1 || got_a[0] !== exp_a[0]) begin
            n_err++;
            $display("FAIL gaps_product: got %0d results want matching 1", got_a.size());
        end
    endtask

    task automatic test_ready_low();
        int w, t, rise;
        clear_logs();
        rise = 0;
        ready_en = 1'b0;
        fork
            client(0, 1, 1'b0, '0, '0, 0, 0, 0, 0, 1'b0, 1'b0, w, t);
            begin
                repeat (6) @(negedge clk);
                ready_en = 1'b1;
                rise = cyc;
            end
        join
        repeat (2) @(negedge clk);
        n_cmp++;
        if (t !== 0 || grant_q.size() !== 1 || grant_q[0].cyc !== rise + 1) begin
            n_err++;
            $display("FAIL ready_grant: got %0d grants first at %0d want 1 at %0d", grant_q.size(),
                     (grant_q.size() > 0) ? grant_q[0].cyc : -1, rise + 1);
        end
        n_cmp++;
        if (got_a.size() !== 1 || got_a[0] !== exp_a[0]) begin
            n_err++;
            $display("FAIL ready_product: got %0d results want matching 1", got_a.size());
        end
    endtask

    task automatic test_reset_mid_load();
        int w, t;
        @(negedge clk);
        a_req = 1'b1;
        w = 0;
        do begin @(negedge clk); w++; end while (!a_grant_out && w < 50);
        a_vld = 1'b1; a_n = 32'h11; a_m = 32'h22;
        @(negedge clk);
        a_n = 32'h33; a_m = 32'h44;
        @(negedge clk);
        a_n = 32'h55; a_m = 32'h66;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_grant_out, b_grant_out, busy_out, mult_valid_out} !== 4'b0 || mult_n_out !== '0 || mult_m_out !== '0) begin
            n_err++;
            $display("FAIL midload_async: got g/g/busy/mv %b n %h want 0000 0",
                     {a_grant_out, b_grant_out, busy_out, mult_valid_out}, mult_n_out);
        end
        @(negedge clk);
        a_vld = 1'b0; a_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        client(0, 1, 1'b0, '0, '0, 0, 0, 0, 0, 1'b0, 1'b0, w, t);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (t !== 0 || fwd_q.size() !== NBLK || fwd_q != sent_q) begin
            n_err++;
            $display("FAIL midload_restart_fwd: got %0d forwards (tmo %0d) want %0d matching", fwd_q.size(), t, NBLK);
        end
        n_cmp++;
        if (got_a.size() !== 1 || got_a[0] !== exp_a[0]) begin
            n_err++;
            $display("FAIL midload_product: got %0d results want matching 1", got_a.size());
        end
    endtask

    task automatic test_b_drop();
        int w, t, k;
        logic seen_g, seen_f;
        clear_logs();
        seen_g = 1'b0; seen_f = 1'b1;
        fork
            client(1, 1, 1'b0, '0, '0, 0, 0, 1, 0, 1'b0, 1'b1, w, t);
            begin
                k = 0;
                do begin @(negedge clk); k++; end while (!b_grant_out && k < 200);
                k = 0;
                do begin @(negedge clk); k++; end while (b_req && k < 200);
                @(negedge clk);
                seen_g = b_grant_out;
                seen_f = b_final_out;
            end
        join
        repeat (2) @(negedge clk);
        n_cmp++;
        if (seen_g !== 1'b1 || seen_f !== 1'b0) begin
            n_err++;
            $display("FAIL bdrop_hold: got grant %b final %b after drop want 1 0", seen_g, seen_f);
        end
        n_cmp++;
        if (t !== 0 || got_b.size() !== 1 || got_b[0] !== exp_b[0] || got_a.size() !== 0 || leak !== 0) begin
            n_err++;
            $display("FAIL bdrop_route: got b %0d a %0d leak %0d want 1 0 0", got_b.size(), got_a.size(), leak);
        end
        n_cmp++;
        if (drop_q.size() !== 1 || final_q.size() !== 1 || drop_q[0].cyc !== final_q[0].cyc) begin
            n_err++;
            $display("FAIL bdrop_release: got drops %0d finals %0d want same-cycle 1/1", drop_q.size(), final_q.size());
        end
    endtask

    task automatic test_stray_result();
        int w, t, k;
        clear_logs();
        @(negedge clk);
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (leak !== 0 || got_a.size() !== 0 || got_b.size() !== 0) begin
            n_err++;
            $display("FAIL stray_idle: got leak %0d finals %0d/%0d want 0", leak, got_a.size(), got_b.size());
        end
        fork
            client(0, 1, 1'b0, '0, '0, 0, 2, 0, 0, 1'b0, 1'b0, w, t);
            begin
                k = 0;
                do begin @(negedge clk); k++; end while (!a_grant_out && k < 200);
                stray = 1'b1;
                @(negedge clk);
                stray = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        n_cmp++;
        if (t !== 0 || got_a.size() !== 1 || got_a[0] !== exp_a[0]) begin
            n_err++;
            $display("FAIL stray_load: got %0d results (tmo %0d) want matching 1", got_a.size(), t);
        end
    endtask

    task automatic test_back_to_back();
        int wa, ta, wb, tb;
        clear_logs();
        fork
            client(0, 3, 1'b0, '0, '0, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'b1, 1'b0, wa, ta);
            client(1, 3, 1'b0, '0, '0, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b1, wb, tb);
        join
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ta !== 0 || tb !== 0 || fwd_q.size() !== 6*NBLK || fwd_q != sent_q) begin
            n_err++;
            $display("FAIL b2b_fwd: got %0d forwards (tmo %0d/%0d) want %0d matching", fwd_q.size(), ta, tb, 6*NBLK);
        end
        for (int i = 0; i < exp_a.size(); i++) begin
            n_cmp++;
            if (i >= got_a.size() || got_a[i] !== exp_a[i]) begin
                n_err++;
                $display("FAIL b2b_a[%0d]: got %0d results want product %h", i, got_a.size(), exp_a[i]);
            end
        end
        for (int i = 0; i < exp_b.size(); i++) begin
            n_cmp++;
            if (i >= got_b.size() || got_b[i] !== exp_b[i]) begin
                n_err++;
                $display("FAIL b2b_b[%0d]: got %0d results want product %h", i, got_b.size(), exp_b[i]);
            end
        end
        n_cmp++;
        if (leak !== 0) begin
            n_err++;
            $display("FAIL b2b_leak: got %0d want 0", leak);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_req = 1'b0; b_req = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
        a_n = '0; a_m = '0; b_n = '0; b_m = '0;
        ready_en = 1'b1;
        stray = 1'b0;
        test_reset();
        test_single_a();
        test_simultaneous();
        test_valid_gaps();
        test_ready_low();
        test_reset_mid_load();
        test_b_drop();
        test_stray_result();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multiplier_arbiter.md
# multiplier_arbiter

Two-requester round-robin arbiter and sequencer that shares one block-serial big-number multiplier (REGISTER_SIZE-bit blocks, BITS_IN_NUM-bit operands, 2×BITS_IN_NUM-bit product) between two clients, A and B.
- It grants one client per job and forwards that client's operand block stream to the multiplier.
- It routes the product block stream back to the same client.
- It holds the grant until the multiplier signals its final output.
- It sits between the encryption/tally pipelines and the single multiplier instance.

## Interface
Parameters:
- REGISTER_SIZE, 32, block width in bits.
- BITS_IN_NUM, 4096, operand width in bits.
- BLOCKS (localparam), BITS_IN_NUM/REGISTER_SIZE, operand blocks per job.

Ports:
- clk_in  input  1  single clock; everything is on its rising edge.
- rst_in  input  1  reset, asynchronous and active-high.
- a_req_in / b_req_in  input  1  client requests a multiplication.
- a_n_in, a_m_in / b_n_in, b_m_in  input  REGISTER_SIZE  operand blocks, least significant first.
- a_valid_in / b_valid_in  input  1  operand block pair valid; honoured only while that client is granted.
- a_grant_out / b_grant_out  output  1  client owns the multiplier.
- a_data_out / b_data_out  output  REGISTER_SIZE  product block.
- a_valid_out / b_valid_out  output  1  product block valid.
- a_final_out / b_final_out  output  1  product complete.
- mult_n_out, mult_m_out  output  REGISTER_SIZE  operand blocks to the multiplier.
- mult_valid_out  output  1  drives the multiplier's valid_in.
- mult_ready_in  input  1  multiplier idle (ready_out).
- mult_data_in  input  REGISTER_SIZE  from the multiplier's data_out.
- mult_valid_in  input  1  from the multiplier's valid_out.
- mult_final_in  input  1  from the multiplier's final_out.
- busy_out  output  1  state ≠ IDLE.

## Operation
- States: IDLE, LOAD, WAIT.
- **IDLE.** Arbitration happens only when mult_ready_in=1 and at least one request is high.
  - Only one request high: grant that client.
  - Both high: grant the client that is not last_served.
  - Record the granted client in owner and go to LOAD.
  - last_served resets to B, so A wins the first tie.
- **LOAD.** Each cycle with the owner's valid_in=1:
  - register its n/m onto mult_n_out/mult_m_out;
  - assert mult_valid_out for one cycle;
  - increment blk_cnt.
- **LOAD, gaps and exit.**
  - Cycles with valid_in=0 drive mult_valid_out=0 and do not count.
  - When the BLOCKS-th block is accepted, set blk_cnt to 0 and go to WAIT.
  - Valid from the non-owner is ignored in all states.
- **WAIT.** mult_valid_out is held 0. The owner receives mult_data_in/valid/final, registered. The non-owner sees valid/final/data = 0.
  - On the cycle mult_final_in=1 is forwarded: last_served ← owner, drop the grant, go to IDLE.
- **Request deasserted after grant.** The job continues. The multiplier cannot be aborted, and the grant is held until final.
- **Result outside WAIT.** mult_valid_in=1 seen outside WAIT is dropped; the arbiter routes results only in WAIT.
- **Reset.** rst_in asynchronously forces:
  - state=IDLE, blk_cnt=0, owner=A, last_served=B;
  - all outputs 0.
  - Reset mid-job abandons it. The multiplier shares rst_in and is reset with it.
- **Counter width.** blk_cnt is $clog2(BLOCKS+1) bits and never wraps; the transition occurs at BLOCKS.

## Timing
- Request to grant: request sampled in IDLE at edge k → grant_out=1 from edge k+1.
- The first operand block is accepted in the cycle grant is seen high. Clients may present valid together with grant.
- Operand forward latency: 1 cycle (client valid at edge k → mult_valid_out at edge k+1).
- Result forward latency: 1 cycle for data, valid and final.
- Grant falls on the same edge that the forwarded final_out rises; busy_out falls with it.
- Minimum IDLE dwell between jobs: 1 cycle. A new grant can issue the edge after returning to IDLE if mult_ready_in=1.
- Load duration: BLOCKS cycles with no gaps.

## Test plan
Benches use BITS_IN_NUM=128 and REGISTER_SIZE=32 (BLOCKS=4), with a behavioural multiplier model or the real multiplier.
- **Single A job.** a_req=1, A sends n=0x...0003, m=0x...0005 as 4 blocks → a_grant 1 cycle later; 4 mult_valid_out pulses, each 1 cycle after input; a_data_out stream equals product 15 in block 0 and zeros elsewhere; a_final pulses once; a_grant then drops; b_* stay 0.
- **Simultaneous requests after reset.** A served first. B is granted exactly one IDLE cycle after A's final. With both still requesting, the next grant goes to A.
- **Valid gaps.** A sends blocks on cycles 0, 2, 5, 6 → exactly 4 forwarded pulses; WAIT entered after the 4th; an extra 5th valid is ignored.
- **mult_ready_in=0 in IDLE with requests high.** No grant while low; grant issues 1 cycle after it rises.
- **Reset asserted mid-LOAD (after 2 blocks).** All outputs 0 immediately, without a clock edge. After release, a new A job completes correctly with blk_cnt restarted.
- **B drops b_req_in during WAIT.** b_grant held; results still routed to B until b_final_out.
